cv32e40x_prefetcher_mo: RTL and testbench

Parametrised multi-outstanding instruction prefetcher. It merges the transaction-issue and response-buffering roles of the current prefetch path into one block, with configurable buffer depth and a configurable outstanding-transaction limit. It issues sequential word-aligned OBI fetch requests, queues responses in a FIFO, and hands words to the aligner/IF stage. Branches flush the FIFO; responses that were already in flight are silently discarded.

---
 rtl/cv32e40x_prefetcher_mo.sv | 187 ++++++++++++++++++
 tb/tb_cv32e40x_prefetcher_mo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_prefetcher_mo.sv
// Multi-outstanding instruction prefetcher: issues sequential word fetches on OBI,
// buffers responses in a FIFO and drops responses that belong to a flushed stream.
module cv32e40x_prefetcher_mo #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 branch_i,
    input  logic [31:0]                          branch_addr_i,
    output logic                                 trans_valid_o,
    input  logic                                 trans_ready_i,
    output logic [31:0]                          trans_addr_o,
    input  logic                                 resp_valid_i,
    input  logic [31:0]                          resp_rdata_i,
    input  logic                                 resp_err_i,
    output logic                                 instr_valid_o,
    input  logic                                 instr_ready_i,
    output logic [31:0]                          instr_rdata_o,
    output logic [31:0]                          instr_addr_o,
    output logic                                 instr_err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 busy_o
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
    } entry_t;

    state_e         state_q, state_d;
    logic [31:0]    fetch_addr_q, fetch_addr_d, hold_addr_q;
    logic [31:0]    branch_word;
    logic [OW-1:0]  outstanding_q, outstanding_d;
    logic [OW-1:0]  discard_q, discard_d;

    entry_t         fifo_q [2**PW];
    logic [PW-1:0]  rptr_q, wptr_q;
    logic [CW-1:0]  count_q;

    logic [31:0]    aq_q [2**AW];
    logic [AW-1:0]  aq_rptr_q, aq_wptr_q;

    logic           credit, grant, hold_grant, rec, push, pop, drop_old;
    entry_t         head;

    function automatic logic [PW-1:0] inc_f(input logic [PW-1:0] p);
        if (32'(p) == DEPTH - 1) return '0;
        return p + PW'(1);
    endfunction

    function automatic logic [AW-1:0] inc_a(input logic [AW-1:0] p);
        if (32'(p) >= MAX_OUTSTANDING - 1) return '0;
        return p + AW'(1);
    endfunction

    assign branch_word = branch_addr_i & ~32'h3;

    // Discard-pending requests count against both limits, keeping credit conservative.
    assign credit = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                    ((32'(outstanding_q) + 32'(count_q)) < DEPTH);

    always_comb begin
        state_d       = state_q;
        trans_valid_o = 1'b0;
        trans_addr_o  = fetch_addr_q;
        case (state_q)
            IDLE: begin
                if (branch_i) state_d = RUN;
            end
            RUN: begin
                trans_valid_o = credit;
                if (branch_i && credit && !trans_ready_i) state_d = HOLD;
            end
            HOLD: begin
                // Old request must stay on the bus until granted; fetch_addr already holds the target.
                trans_valid_o = 1'b1;
                trans_addr_o  = hold_addr_q;
                if (trans_ready_i) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant      = trans_valid_o && trans_ready_i;
    assign hold_grant = grant && (state_q == HOLD);
    assign rec        = grant && (state_q == RUN) && !branch_i;
    assign drop_old   = resp_valid_i && (discard_q != '0);
    assign push       = resp_valid_i && !branch_i && (discard_q == '0);
    assign pop        = instr_valid_o && instr_ready_i && !branch_i;

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (branch_i)                        fetch_addr_d = branch_word;
        else if (grant && state_q == RUN)    fetch_addr_d = fetch_addr_q + 32'd4;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({grant, resp_valid_i})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // On a branch everything still in flight (incl. this cycle's grant) belongs to the old stream.
    always_comb begin
        discard_d = discard_q;
        if (branch_i) begin
            discard_d = outstanding_d;
        end else begin
            if (hold_grant) discard_d = discard_d + OW'(1);
            if (drop_old)   discard_d = discard_d - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_addr_q  <= '0;
            hold_addr_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            aq_rptr_q     <= '0;
            aq_wptr_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (state_q == RUN && state_d == HOLD) hold_addr_q <= fetch_addr_q;
            if (branch_i) begin
                rptr_q    <= '0;
                wptr_q    <= '0;
                count_q   <= '0;
                aq_rptr_q <= '0;
                aq_wptr_q <= '0;
            end else begin
                if (push) wptr_q <= inc_f(wptr_q);
                if (pop)  rptr_q <= inc_f(rptr_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
                if (rec)  aq_wptr_q <= inc_a(aq_wptr_q);
                if (push) aq_rptr_q <= inc_a(aq_rptr_q);
            end
        end
    end

    // Storage needs no reset: outputs are gated by instr_valid_o.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= {resp_rdata_i, resp_err_i, aq_q[aq_rptr_q]};
        if (rec)  aq_q[aq_wptr_q] <= trans_addr_o;
    end

    assign head          = fifo_q[rptr_q];
    assign instr_valid_o = (count_q != '0);
    assign instr_rdata_o = instr_valid_o ? head.rdata : '0;
    assign instr_addr_o  = instr_valid_o ? head.addr  : '0;
    assign instr_err_o   = instr_valid_o ? head.err   : 1'b0;
    assign outstanding_o = outstanding_q;
    assign busy_o        = (outstanding_q != '0) || (count_q != '0);

`ifndef SYNTHESIS
    a_no_spurious_resp : assert property (@(posedge clk) disable iff (rst)
        resp_valid_i |-> (outstanding_q != '0));
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        (push && (32'(count_q) == DEPTH)) |-> pop);
    a_addr_stable : assert property (@(posedge clk) disable iff (rst)
        (trans_valid_o && !trans_ready_i) |=> (trans_valid_o && $stable(trans_addr_o)));
`endif

endmodule

// File: tb/tb_cv32e40x_prefetcher_mo.sv
// Directed bench for the multi-outstanding prefetcher: in-order bus model with
// 1-cycle response latency and a delivery log checked against hand-computed addresses.
module tb_cv32e40x_prefetcher_mo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        trans_valid, trans_ready = 1'b0;
    logic [31:0] trans_addr;
    logic        resp_valid = 1'b0, resp_err = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic        instr_valid, instr_ready = 1'b0, instr_err;
    logic [31:0] instr_rdata, instr_addr;
    logic [1:0]  outstanding;
    logic        busy;

    logic        resp_en  = 1'b1;
    logic [31:0] err_addr = 32'hDEAD_BEE1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } dlv_t;

    logic [31:0] pend[$];
    logic [31:0] gnt_log[$];
    dlv_t        dq[$];

    always #5 clk = ~clk;

    cv32e40x_prefetcher_mo #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .branch_i(branch), .branch_addr_i(branch_addr),
        .trans_valid_o(trans_valid), .trans_ready_i(trans_ready), .trans_addr_o(trans_addr),
        .resp_valid_i(resp_valid), .resp_rdata_i(resp_rdata), .resp_err_i(resp_err),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_rdata_o(instr_rdata), .instr_addr_o(instr_addr), .instr_err_o(instr_err),
        .outstanding_o(outstanding), .busy_o(busy)
    );

    // Bus model: in-order, response presented the cycle after the grant.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (resp_valid && pend.size() > 0) void'(pend.pop_front());
            if (trans_valid && trans_ready) begin
                pend.push_back(trans_addr);
                gnt_log.push_back(trans_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && resp_en && pend.size() > 0) begin
            resp_valid = 1'b1;
            resp_rdata = ~pend[0];
            resp_err   = (pend[0] == err_addr);
        end else begin
            resp_valid = 1'b0;
            resp_rdata = '0;
            resp_err   = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst && instr_valid && instr_ready && !branch)
            dq.push_back('{addr: instr_addr, data: instr_rdata, err: instr_err});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; branch = 1'b0; trans_ready = 1'b0; instr_ready = 1'b0; resp_en = 1'b1;
        err_addr = 32'hDEAD_BEE1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic do_branch(input logic [31:0] a);
        branch_addr = a; branch = 1'b1;
        step(1);
        branch = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        n_vec++; if (trans_valid !== 1'b0)    begin n_err++; $display("FAIL rst_trans_valid got %b want 0", trans_valid); end
        n_vec++; if (trans_addr !== 32'h0)    begin n_err++; $display("FAIL rst_trans_addr got %h want 0", trans_addr); end
        n_vec++; if (instr_valid !== 1'b0)    begin n_err++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
        n_vec++; if ({instr_rdata, instr_addr, instr_err} !== 65'h0) begin n_err++; $display("FAIL rst_instr_bus got %h/%h/%b want 0", instr_rdata, instr_addr, instr_err); end
        n_vec++; if ({outstanding, busy} !== 3'b0) begin n_err++; $display("FAIL rst_counters got %0d/%b want 0", outstanding, busy); end
        rst = 1'b0;
        trans_ready = 1'b1;
        step(4);
        // IDLE issues nothing until a branch
        n_vec++; if (trans_valid !== 1'b0)    begin n_err++; $display("FAIL idle_no_req got %b want 0", trans_valid); end
    endtask

    task automatic test_sequential();
        int bd, bg;
        do_reset();
        trans_ready = 1'b1; instr_ready = 1'b1;
        bd = dq.size(); bg = gnt_log.size();
        do_branch(32'h0000_1002);
        n_vec++; if (trans_valid !== 1'b1 || trans_addr !== 32'h1000) begin n_err++; $display("FAIL seq_first_req got %b/%h want 1/00001000", trans_valid, trans_addr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_valid_e1 got %b want 0", instr_valid); end
        step(1);
        n_vec++; if (instr_valid !== 1'b0 || trans_addr !== 32'h1004) begin n_err++; $display("FAIL seq_e2 got %b/%h want 0/00001004", instr_valid, trans_addr); end
        step(1);
        n_vec++; if (instr_valid !== 1'b1 || instr_addr !== 32'h1000 || instr_rdata !== 32'hFFFF_EFFF) begin n_err++; $display("FAIL seq_first_word got %b/%h/%h want 1/00001000/ffffefff", instr_valid, instr_addr, instr_rdata); end
        step(8);
        n_vec++; if (dq.size() - bd < 6 || gnt_log.size() - bg < 6) begin n_err++; $display("FAIL seq_counts got %0d/%0d want >=6", dq.size() - bd, gnt_log.size() - bg); end
        for (int i = 0; i < 6; i++) begin
            if (dq.size() > bd + i) begin
                n_vec++; if (dq[bd+i].addr !== 32'h1000 + 32'(4*i) || dq[bd+i].data !== ~(32'h1000 + 32'(4*i)))
                    begin n_err++; $display("FAIL seq_dlv[%0d] got %h/%h want %h", i, dq[bd+i].addr, dq[bd+i].data, 32'h1000 + 32'(4*i)); end
            end
            if (gnt_log.size() > bg + i) begin
                n_vec++; if (gnt_log[bg+i] !== 32'h1000 + 32'(4*i))
                    begin n_err++; $display("FAIL seq_gnt[%0d] got %h want %h", i, gnt_log[bg+i], 32'h1000 + 32'(4*i)); end
            end
        end
    endtask

    task automatic test_stall();
        int bg;
        do_reset();
        trans_ready = 1'b1; instr_ready = 1'b0;
        bg = gnt_log.size();
        do_branch(32'h0000_1000);
        step(12);
        n_vec++; if (gnt_log.size() - bg != 4) begin n_err++; $display("FAIL stall_grants got %0d want 4", gnt_log.size() - bg); end
        n_vec++; if (trans_valid !== 1'b0 || outstanding !== 2'd0) begin n_err++; $display("FAIL stall_no_credit got %b/%0d want 0/0", trans_valid, outstanding); end
        n_vec++; if (instr_valid !== 1'b1 || instr_addr !== 32'h1000 || busy !== 1'b1) begin n_err++; $display("FAIL stall_head got %b/%h/%b want 1/00001000/1", instr_valid, instr_addr, busy); end
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        n_vec++; if (instr_addr !== 32'h1004) begin n_err++; $display("FAIL stall_pop_head got %h want 00001004", instr_addr); end
        step(8);
        n_vec++; if (gnt_log.size() - bg != 5) begin n_err++; $display("FAIL stall_one_more got %0d want 5", gnt_log.size() - bg); end
        n_vec++; if (trans_valid !== 1'b0 || instr_addr !== 32'h1004) begin n_err++; $display("FAIL stall_refull got %b/%h want 0/00001004", trans_valid, instr_addr); end
    endtask

    task automatic test_branch_discard();
        int bd;
        do_reset();
        resp_en = 1'b0; trans_ready = 1'b1; instr_ready = 1'b1;
        do_branch(32'h0000_1000);
        step(2);
        n_vec++; if (outstanding !== 2'd2 || trans_valid !== 1'b0) begin n_err++; $display("FAIL disc_two_out got %0d/%b want 2/0", outstanding, trans_valid); end
        bd = dq.size();
        do_branch(32'h0000_2000);
        resp_en = 1'b1;
        n_vec++; if (instr_valid !== 1'b0 || outstanding !== 2'd2) begin n_err++; $display("FAIL disc_after_branch got %b/%0d want 0/2", instr_valid, outstanding); end
        step(10);
        n_vec++; if (dq.size() - bd < 2) begin n_err++; $display("FAIL disc_count got %0d want >=2", dq.size() - bd); end
        if (dq.size() > bd) begin
            n_vec++; if (dq[bd].addr !== 32'h2000 || dq[bd].data !== 32'hFFFF_DFFF) begin n_err++; $display("FAIL disc_first got %h/%h want 00002000/ffffdfff", dq[bd].addr, dq[bd].data); end
        end
        if (dq.size() > bd + 1) begin
            n_vec++; if (dq[bd+1].addr !== 32'h2004) begin n_err++; $display("FAIL disc_second got %h want 00002004", dq[bd+1].addr); end
        end
    endtask

    task automatic test_hold();
        int bd, bg;
        do_reset();
        trans_ready = 1'b0; instr_ready = 1'b1;
        bd = dq.size(); bg = gnt_log.size();
        do_branch(32'h0000_100C);
        n_vec++; if (trans_valid !== 1'b1 || trans_addr !== 32'h100C) begin n_err++; $display("FAIL hold_req got %b/%h want 1/0000100c", trans_valid, trans_addr); end
        do_branch(32'h0000_3000);
        step(2);
        n_vec++; if (trans_valid !== 1'b1 || trans_addr !== 32'h100C) begin n_err++; $display("FAIL hold_stable got %b/%h want 1/0000100c", trans_valid, trans_addr); end
        trans_ready = 1'b1;
        step(1);
        n_vec++; if (trans_valid !== 1'b1 || trans_addr !== 32'h3000) begin n_err++; $display("FAIL hold_next got %b/%h want 1/00003000", trans_valid, trans_addr); end
        step(8);
        n_vec++; if (gnt_log.size() - bg < 2) begin n_err++; $display("FAIL hold_gcount got %0d want >=2", gnt_log.size() - bg); end
        if (gnt_log.size() > bg + 1) begin
            n_vec++; if (gnt_log[bg] !== 32'h100C || gnt_log[bg+1] !== 32'h3000) begin n_err++; $display("FAIL hold_gseq got %h,%h want 0000100c,00003000", gnt_log[bg], gnt_log[bg+1]); end
        end
        n_vec++; if (dq.size() - bd < 1) begin n_err++; $display("FAIL hold_dcount got %0d want >=1", dq.size() - bd); end
        if (dq.size() > bd) begin
            n_vec++; if (dq[bd].addr !== 32'h3000) begin n_err++; $display("FAIL hold_dfirst got %h want 00003000", dq[bd].addr); end
        end
    endtask

    task automatic test_error();
        int bd;
        logic [3:0] want_err;
        do_reset();
        err_addr = 32'h0000_1008;
        trans_ready = 1'b1; instr_ready = 1'b1;
        bd = dq.size();
        do_branch(32'h0000_1000);
        step(10);
        want_err = 4'b0100;
        n_vec++; if (dq.size() - bd < 4) begin n_err++; $display("FAIL err_count got %0d want >=4", dq.size() - bd); end
        for (int i = 0; i < 4; i++) begin
            if (dq.size() > bd + i) begin
                n_vec++; if (dq[bd+i].err !== want_err[i] || dq[bd+i].addr !== 32'h1000 + 32'(4*i))
                    begin n_err++; $display("FAIL err_dlv[%0d] got %b/%h want %b/%h", i, dq[bd+i].err, dq[bd+i].addr, want_err[i], 32'h1000 + 32'(4*i)); end
            end
        end
    endtask

    task automatic test_wrap_and_async_reset();
        int bd, bg;
        do_reset();
        trans_ready = 1'b1; instr_ready = 1'b1;
        bd = dq.size(); bg = gnt_log.size();
        do_branch(32'hFFFF_FFF8);
        step(5);
        n_vec++; if (gnt_log.size() - bg < 3) begin n_err++; $display("FAIL wrap_gcount got %0d want >=3", gnt_log.size() - bg); end
        if (gnt_log.size() > bg + 2) begin
            n_vec++; if (gnt_log[bg+1] !== 32'hFFFF_FFFC || gnt_log[bg+2] !== 32'h0) begin n_err++; $display("FAIL wrap_gnt got %h,%h want fffffffc,00000000", gnt_log[bg+1], gnt_log[bg+2]); end
        end
        if (dq.size() > bd + 2) begin
            n_vec++; if (dq[bd+2].addr !== 32'h0 || dq[bd+2].data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_dlv got %h/%h want 00000000/ffffffff", dq[bd+2].addr, dq[bd+2].data); end
        end else begin
            n_vec++; n_err++; $display("FAIL wrap_dcount got %0d want >=3", dq.size() - bd);
        end
        n_vec++; if (busy !== 1'b1 || trans_valid !== 1'b1) begin n_err++; $display("FAIL burst_active got %b/%b want 1/1", busy, trans_valid); end
        // Reset lands mid-cycle, well away from any clock edge
        rst = 1'b1;
        #1;
        n_vec++; if ({trans_valid, instr_valid, busy, instr_err} !== 4'b0) begin n_err++; $display("FAIL async_rst_flags got %b%b%b%b want 0000", trans_valid, instr_valid, busy, instr_err); end
        n_vec++; if (trans_addr !== 32'h0 || instr_addr !== 32'h0 || instr_rdata !== 32'h0 || outstanding !== 2'd0) begin n_err++; $display("FAIL async_rst_bus got %h/%h/%h/%0d want 0", trans_addr, instr_addr, instr_rdata, outstanding); end
        step(2);
        rst = 1'b0;
        step(3);
        n_vec++; if (trans_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_idle got %b/%b want 0/0", trans_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_discard();
        test_hold();
        test_error();
        test_wrap_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
